// File: rtl/alu_pkg.sv
// alu_pkg: shared defaults, ALU opcode values and issue-FSM state encoding
// for the register-file / issue / writeback side of the ALU datapath.
package alu_pkg;

  localparam int DEF_WIDTH = 32;  // operand / result width
  localparam int DEF_NREG  = 16;  // register count, entry 0 reads as zero
  localparam int DEF_AW    = 4;   // register address width
  localparam int DEF_OPW   = 2;   // ALU opcode width

  localparam logic [DEF_OPW-1:0] OP_AND = 2'd0;
  localparam logic [DEF_OPW-1:0] OP_OR  = 2'd1;
  localparam logic [DEF_OPW-1:0] OP_ADD = 2'd2;
  localparam logic [DEF_OPW-1:0] OP_SUB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file, entry 0 hardwired to zero.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high clear of all entries
//   we_a_i/waddr_a_i/wdata_a_i    write port A (external load)
//   we_b_i/waddr_b_i/wdata_b_i    write port B (writeback), applied after port A
//   rs2_addr_i/rs2_data_o         combinational read port (operand A)
//   rs3_addr_i/rs3_data_o         combinational read port (operand B)
//   dbg_addr_i/dbg_data_o         combinational debug read port
// Writes to address 0 are dropped; reads see contents after the last edge.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_a_i,
  input  logic [AW-1:0]    waddr_a_i,
  input  logic [WIDTH-1:0] wdata_a_i,
  input  logic             we_b_i,
  input  logic [AW-1:0]    waddr_b_i,
  input  logic [WIDTH-1:0] wdata_b_i,
  input  logic [AW-1:0]    rs2_addr_i,
  input  logic [AW-1:0]    rs3_addr_i,
  input  logic [AW-1:0]    dbg_addr_i,
  output logic [WIDTH-1:0] rs2_data_o,
  output logic [WIDTH-1:0] rs3_data_o,
  output logic [WIDTH-1:0] dbg_data_o
);

  logic [WIDTH-1:0] mem_q [NREG];

  // Register storage: clear on reset, otherwise apply both write ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (we_a_i && (waddr_a_i != {AW{1'b0}})) begin
        mem_q[waddr_a_i] <= wdata_a_i;
      end
      // Port B last so that it would also win an address clash here.
      if (we_b_i && (waddr_b_i != {AW{1'b0}})) begin
        mem_q[waddr_b_i] <= wdata_b_i;
      end
    end
  end

  // Entry 0 is forced to zero on every read port.
  assign rs2_data_o = (rs2_addr_i == {AW{1'b0}}) ? {WIDTH{1'b0}} : mem_q[rs2_addr_i];
  assign rs3_data_o = (rs3_addr_i == {AW{1'b0}}) ? {WIDTH{1'b0}} : mem_q[rs3_addr_i];
  assign dbg_data_o = (dbg_addr_i == {AW{1'b0}}) ? {WIDTH{1'b0}} : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: operand issue and result writeback around a combinational ALU.
// One command per three cycles: accept (IDLE) -> ISSUE (ALU evaluates the
// registered operands, result sampled) -> EXEC (result written back, done
// pulse raised on the following cycle).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE, not in reset)
//   cmd_op/cmd_rd/cmd_rs2/cmd_rs3    opcode, destination and source registers
//   alu_op/alu_r2/alu_r3             registered opcode and operands to the ALU
//   alu_r1                           combinational ALU result
//   ext_we/ext_addr/ext_data         external register load, honoured in any state
//   dbg_addr/dbg_data                combinational register read-back
//   done/done_rd/done_data           one-cycle completion pulse with destination and result
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW,
  parameter int OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [AW-1:0]    cmd_rs3,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             done,
  output logic [AW-1:0]    done_rd,
  output logic [WIDTH-1:0] done_data
);

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] result_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_r2_q, alu_r3_q;
  logic             done_q;
  logic [AW-1:0]    done_rd_q;
  logic [WIDTH-1:0] done_data_q;

  logic             wb_we_s;
  logic             ext_we_s;
  logic [WIDTH-1:0] rs2_data_s, rs3_data_s;

  // Writeback and external-load enables; writeback wins an address clash.
  always_comb begin
    wb_we_s  = 1'b0;
    ext_we_s = 1'b0;
    if (state_q == ST_EXEC) begin
      wb_we_s = 1'b1;
    end else begin
      wb_we_s = 1'b0;
    end
    if (wb_we_s && (ext_addr == rd_q)) begin
      ext_we_s = 1'b0;
    end else begin
      ext_we_s = ext_we;
    end
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_a_i     (ext_we_s),
    .waddr_a_i  (ext_addr),
    .wdata_a_i  (ext_data),
    .we_b_i     (wb_we_s),
    .waddr_b_i  (rd_q),
    .wdata_b_i  (result_q),
    .rs2_addr_i (cmd_rs2),
    .rs3_addr_i (cmd_rs3),
    .dbg_addr_i (dbg_addr),
    .rs2_data_o (rs2_data_s),
    .rs3_data_o (rs3_data_s),
    .dbg_data_o (dbg_data)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  // Next-state logic for the accept / issue / execute sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand capture, result sample, completion report.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= {AW{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      alu_op_q    <= {OPW{1'b0}};
      alu_r2_q    <= {WIDTH{1'b0}};
      alu_r3_q    <= {WIDTH{1'b0}};
      done_q      <= 1'b0;
      done_rd_q   <= {AW{1'b0}};
      done_data_q <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Operands come from pre-edge contents: no forwarding of a
          // same-edge external load.
          if (cmd_valid) begin
            rd_q     <= cmd_rd;
            alu_op_q <= cmd_op;
            alu_r2_q <= rs2_data_s;
            alu_r3_q <= rs3_data_s;
          end
        end
        ST_ISSUE: begin
          result_q <= alu_r1;
        end
        ST_EXEC: begin
          done_q      <= 1'b1;
          done_rd_q   <= rd_q;
          done_data_q <= result_q;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_r2    = alu_r2_q;
  assign alu_r3    = alu_r3_q;
  assign done      = done_q;
  assign done_rd   = done_rd_q;
  assign done_data = done_data_q;

endmodule
